fft_frame_ctrl: RTL
===================

// Module: fft_frame_ctrl
// PURPOSE
//  Frame sequencer in front of the max_10_index_frequency FFT core. Gates ADC samples into the core in FFT_LEN-sample
//  frames, drives clk_enable/reset, flushes the pipeline, captures index_max on valid_out and presents it via ready/valid.
//  Sits between the ADC sample stream and the LED/UART consumer in index_fft_qip.
// PARAMETERS
//  DATA_W   12    ADC sample / core rx_in width (ufix12)
//  IDX_W    8     core index_max width (uint8)
//  FFT_LEN  256   samples per frame (power of 2, >=4)
//  TIMEOUT  1024  max WAIT cycles for valid_out before abort (>=2)
// PORTS
//  clk_in        in   1       system clock, all logic on rising edge
//  reset_n       in   1       asynchronous active-low reset
//  start         in   1       pulse: begin one frame (ignored unless IDLE)
//  cont_mode     in   1       1 = re-arm automatically after each capture
//  abort         in   1       pulse: return to IDLE from any state
//  clr_flags     in   1       pulse: clear overrun/timeout sticky flags
//  adc_valid     in   1       sample strobe
//  adc_data      in   DATA_W  ADC sample
//  fft_reset     out  1       core reset, active-high, sync to clk_in
//  fft_ce        out  1       core clk_enable
//  fft_rx_in     out  DATA_W  core rx_in
//  fft_valid_out in   1       core valid_out
//  fft_index_max in   IDX_W   core index_max
//  res_valid     out  1       result available
//  res_ready     in   1       consumer accepts result
//  res_idx       out  IDX_W   captured peak bin
//  busy          out  1       state != IDLE
//  overrun       out  1       sticky: unread result overwritten
//  timeout_err   out  1       sticky: WAIT exceeded TIMEOUT
//  frame_cnt     out  16      completed captures, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 (fft_reset=0, fft_ce=0, fft_rx_in=0, res_*=0, flags=0, frame_cnt=0).
//  FSM: IDLE -> CLR -> FILL -> WAIT -> (FILL via CLR if cont_mode, else IDLE).
//   IDLE: fft_ce=0. start=1 or cont_mode=1 -> CLR.
//   CLR : exactly 1 cycle, fft_reset=1, fft_ce=0; sample counter := 0 -> FILL.
//   FILL: registered outputs: fft_ce(t+1)=adc_valid(t), fft_rx_in(t+1)=adc_data(t) (1-cycle latency);
//         fft_rx_in holds when adc_valid=0. Counter +1 per adc_valid; adc_valid with count==FFT_LEN-1 -> WAIT.
//   WAIT: fft_ce=1, fft_rx_in=0 (zero flush); wait counter +1 per cycle. fft_valid_out=1 -> capture
//         res_idx:=fft_index_max, res_valid:=1, frame_cnt+1; next = CLR if cont_mode else IDLE.
//         Wait count reaching TIMEOUT-1 without valid -> timeout_err:=1, IDLE, no capture.
//   fft_valid_out outside WAIT is ignored.
//  Handshake: res_valid holds with stable res_idx until res_valid&res_ready; then res_valid:=0 next cycle.
//   Capture while res_valid=1 and no same-cycle ready: overwrite res_idx, overrun:=1.
//   Capture and accept in same cycle: new result loaded, res_valid stays 1, no overrun.
//  abort: highest priority; any state -> IDLE next cycle, fft_ce=0, counters cleared; res_* and flags untouched.
//  start during busy ignored; cont_mode dropped mid-frame finishes current frame then IDLE.
//  clr_flags clears overrun/timeout_err; a same-cycle set event wins.
//  Counters: sample counter $clog2(FFT_LEN) bits, wait counter $clog2(TIMEOUT) bits, no wrap-around in use.
// CONFIGURATION
//  FFT_FRAME_CTRL_STABLE_EN defined: capture is published only if fft_index_max equals the previous frame's
//   captured index (internal last_idx register, invalid after reset/abort); non-matching frame updates last_idx,
//   increments frame_cnt, no res_valid. Undefined: every capture published directly.
// STRUCTURE
//  Package fft_ctrl_pkg: state enum (IDLE, CLR, FILL, WAIT), default DATA_W/IDX_W/FFT_LEN, FRAME_CNT_W=16.
//  One sub-module: fft_result_slot (res_idx/res_valid register, ready/valid, overrun detect); FSM + counters in top.
// TESTING
//  1 reset mid-FILL (count=100) -> all outputs 0 same cycle, IDLE; start after release -> one CLR pulse.
//  2 start, 256 contiguous samples, valid_out with idx=0x2A 40 cycles later -> res_idx=0x2A, res_valid=1, frame_cnt=1.
//  3 adc_valid 50% duty -> fft_ce mirrors adc_valid 1 cycle later; WAIT entered after 256th valid sample only.
//  4 cont_mode=1, res_ready=0, two frames idx 0x10,0x11 -> res_idx=0x11, overrun=1; clr_flags -> overrun=0.
//  5 no valid_out in WAIT -> timeout_err=1 after TIMEOUT cycles, IDLE, res_valid unchanged.
//  6 abort at FILL sample 10 -> IDLE next cycle, fft_ce=0; STABLE_EN build: idx 5,5 -> one result; 5,6 -> none.

Source files
------------

// File: rtl/fft_frame_ctrl_pkg.sv
// Shared types and defaults for the FFT frame sequencer.
package fft_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StClr,
    StFill,
    StWait
  } state_e;

  localparam int unsigned DefDataW   = 12;
  localparam int unsigned DefIdxW    = 8;
  localparam int unsigned DefFftLen  = 256;
  localparam int unsigned DefTimeout = 1024;
  localparam int unsigned FRAME_CNT_W = 16;

endpackage

// File: rtl/fft_frame_ctrl_if.sv
// Control, ADC, FFT-core and result signals of the frame sequencer.
interface fft_frame_ctrl_if
  import fft_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned IDX_W  = DefIdxW
) ();

  logic                   start;
  logic                   cont_mode;
  logic                   abort;
  logic                   clr_flags;
  logic                   adc_valid;
  logic [DATA_W-1:0]      adc_data;
  logic                   fft_reset;
  logic                   fft_ce;
  logic [DATA_W-1:0]      fft_rx_in;
  logic                   fft_valid_out;
  logic [IDX_W-1:0]       fft_index_max;
  logic                   res_valid;
  logic                   res_ready;
  logic [IDX_W-1:0]       res_idx;
  logic                   busy;
  logic                   overrun;
  logic                   timeout_err;
  logic [FRAME_CNT_W-1:0] frame_cnt;

  modport master (
    output start, cont_mode, abort, clr_flags, adc_valid, adc_data,
    output fft_valid_out, fft_index_max, res_ready,
    input  fft_reset, fft_ce, fft_rx_in, res_valid, res_idx,
    input  busy, overrun, timeout_err, frame_cnt
  );

  modport slave (
    input  start, cont_mode, abort, clr_flags, adc_valid, adc_data,
    input  fft_valid_out, fft_index_max, res_ready,
    output fft_reset, fft_ce, fft_rx_in, res_valid, res_idx,
    output busy, overrun, timeout_err, frame_cnt
  );

endinterface

// File: rtl/fft_frame_ctrl_result_slot.sv
// Single-entry result register with ready/valid output and sticky overrun flag.
module fft_result_slot #(
  parameter int unsigned IDX_W = 8
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic [IDX_W-1:0] i_idx,
  input  logic             i_ready,
  input  logic             i_clr_flags,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_overrun
);

  logic             r_valid;
  logic [IDX_W-1:0] r_idx;
  logic             r_overrun;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_valid   <= 1'b0;
      r_idx     <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (i_load) begin
        r_valid <= 1'b1;
        r_idx   <= i_idx;
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
      // An unread result being replaced is an overrun; a same-cycle accept is not.
      if (i_load && r_valid && !i_ready) begin
        r_overrun <= 1'b1;
      end else if (i_clr_flags) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign o_valid   = r_valid;
  assign o_idx     = r_idx;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the peak-bin FFT core: fill, flush, capture, publish.
// Optional FFT_FRAME_CTRL_STABLE_EN publishes only when two consecutive frames agree.
module fft_frame_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned IDX_W   = DefIdxW,
  parameter int unsigned FFT_LEN = DefFftLen,
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input  logic          clk_in,
  input  logic          reset_n,
  fft_frame_ctrl_if.slave bus
);

  localparam int unsigned SampW = $clog2(FFT_LEN);
  localparam int unsigned WaitW = $clog2(TIMEOUT);
  localparam logic [SampW-1:0] SampLast = SampW'(FFT_LEN - 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

  state_e                 r_state, w_state_nxt;
  logic [SampW-1:0]       r_samp_cnt, w_samp_nxt;
  logic [WaitW-1:0]       r_wait_cnt, w_wait_nxt;
  logic                   r_ce, w_ce_nxt;
  logic [DATA_W-1:0]      r_rx, w_rx_nxt;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;
  logic                   r_timeout_err;
  logic                   w_capture;
  logic                   w_timeout;
  logic                   w_publish;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    if (bus.abort) begin
      w_state_nxt = StIdle;
    end else begin
      unique case (r_state)
        StIdle: if (bus.start || bus.cont_mode) w_state_nxt = StClr;
        StClr:  w_state_nxt = StFill;
        StFill: if (bus.adc_valid && (r_samp_cnt == SampLast)) w_state_nxt = StWait;
        StWait: begin
          if (bus.fft_valid_out) begin
            w_capture   = 1'b1;
            w_state_nxt = bus.cont_mode ? StClr : StIdle;
          end else if (r_wait_cnt == WaitLast) begin
            w_timeout   = 1'b1;
            w_state_nxt = StIdle;
          end
        end
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  // Core-facing outputs are registered one cycle behind the sample stream.
  always_comb begin
    w_samp_nxt = r_samp_cnt;
    w_wait_nxt = '0;
    w_ce_nxt   = 1'b0;
    w_rx_nxt   = r_rx;
    if (bus.abort) begin
      w_samp_nxt = '0;
      w_rx_nxt   = '0;
    end else begin
      case (r_state)
        StIdle: w_rx_nxt = '0;
        StClr: begin
          w_samp_nxt = '0;
          w_rx_nxt   = '0;
        end
        StFill: begin
          if (bus.adc_valid) begin
            w_samp_nxt = r_samp_cnt + 1'b1;
            w_rx_nxt   = bus.adc_data;
            w_ce_nxt   = 1'b1;
          end
        end
        StWait: begin
          w_wait_nxt = r_wait_cnt + 1'b1;
          w_ce_nxt   = (w_state_nxt == StWait);
          w_rx_nxt   = '0;
        end
        default: w_rx_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_samp_cnt    <= '0;
      r_wait_cnt    <= '0;
      r_ce          <= 1'b0;
      r_rx          <= '0;
      r_frame_cnt   <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_samp_cnt <= w_samp_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_ce       <= w_ce_nxt;
      r_rx       <= w_rx_nxt;
      if (w_capture) r_frame_cnt <= r_frame_cnt + 1'b1;
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end else if (bus.clr_flags) begin
        r_timeout_err <= 1'b0;
      end
    end
  end

`ifdef FFT_FRAME_CTRL_STABLE_EN
  logic [IDX_W-1:0] r_last_idx;
  logic             r_last_vld;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_last_idx <= '0;
      r_last_vld <= 1'b0;
    end else if (bus.abort) begin
      r_last_vld <= 1'b0;
    end else if (w_capture) begin
      r_last_idx <= bus.fft_index_max;
      r_last_vld <= 1'b1;
    end
  end

  assign w_publish = w_capture && r_last_vld && (bus.fft_index_max == r_last_idx);
`else
  assign w_publish = w_capture;
`endif

  fft_result_slot #(
    .IDX_W (IDX_W)
  ) u_slot (
    .clk_in      (clk_in),
    .reset_n     (reset_n),
    .i_load      (w_publish),
    .i_idx       (bus.fft_index_max),
    .i_ready     (bus.res_ready),
    .i_clr_flags (bus.clr_flags),
    .o_valid     (bus.res_valid),
    .o_idx       (bus.res_idx),
    .o_overrun   (bus.overrun)
  );

  always_comb begin
    bus.fft_reset   = (r_state == StClr);
    bus.busy        = (r_state != StIdle);
    bus.fft_ce      = r_ce;
    bus.fft_rx_in   = r_rx;
    bus.timeout_err = r_timeout_err;
    bus.frame_cnt   = r_frame_cnt;
  end

endmodule
